stencil_sweep_ctrl: RTL and testbench
=====================================

STENCIL_SWEEP_CTRL -- requirements
Module: stencil_sweep_ctrl

Interface
REQ-001 Parameter N_CELLS, default 25, number of grid cells swept per pass (cells 0..N_CELLS-1).
REQ-002 Parameter SWEEP_W, default 8, width of the sweep limit and sweep counter.
REQ-003 Port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  in  1  reset, synchronous, active-high.
REQ-005 Port cmd_start  in  1  one-cycle pulse that begins a run.
REQ-006 Port cmd_stop  in  1  one-cycle pulse that aborts a run.
REQ-007 Port sweep_limit  in  SWEEP_W  number of sweeps per run; 0 means unlimited.
REQ-008 Port host_req  in  1  host requests one grid access this cycle.
REQ-009 Port host_we  in  1  host access is a write (1) or a read (0).
REQ-010 Port host_addr  in  5  host cell address.
REQ-011 Port host_gnt  out  1  host access performed this cycle (combinational).
REQ-012 Port eng_delta_nz  in  1  datapath flag: new value differs from old value for the current engine cell.
REQ-013 Port eng_en  out  1  engine update performed this cycle.
REQ-014 Port mem_addr  out  5  grid address for this cycle's access.
REQ-015 Port mem_we  out  1  grid write strobe.
REQ-016 Port mem_src  out  1  grid write-data select: 0 = engine, 1 = host.
REQ-017 Port busy / done / converged  out  1 each  status flags.
REQ-018 Port sweeps_done  out  SWEEP_W  number of sweeps completed in the current or last run.

Function
REQ-019 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-020 Exactly one grid access SHALL occur per cycle, so host_gnt and eng_en are never both 1.
REQ-021 In IDLE and DONE, host_gnt SHALL equal host_req; mem_addr=host_addr, mem_we=host_req&host_we, mem_src=1.
REQ-022 In RUN without host_req, the controller SHALL set eng_en=1, mem_addr=cell_idx, mem_we=1 and mem_src=0, and SHALL then advance cell_idx.
REQ-023 In RUN with host_req, the host SHALL be granted unless the previous cycle was a host grant; under sustained contention, grants therefore alternate host/engine, starting with the host.
REQ-024 cell_idx SHALL wrap from N_CELLS-1 to 0. The wrap completes a sweep: sweeps_done increments, saturating at all-ones.
REQ-025 A sticky activity bit SHALL OR eng_delta_nz over every engine update of a sweep and clear at each sweep start.
REQ-026 At sweep completion, if the activity bit (including the final cell) is 0, the FSM SHALL set converged=1 and move to DONE.
REQ-027 Otherwise, at sweep completion, if sweep_limit≠0 and the new sweeps_done equals sweep_limit, the FSM SHALL move to DONE with converged=0.
REQ-028 IDLE or DONE with cmd_start SHALL enter RUN with cell_idx=0, sweeps_done=0, converged=0 and done=0.
REQ-029 cmd_stop in RUN SHALL still complete the current cycle's access, then enter IDLE with done=0. sweeps_done holds its value and a partial sweep is not counted.
REQ-030 When cmd_start and cmd_stop are asserted in the same cycle, cmd_stop SHALL win and the FSM SHALL stay in or enter IDLE.
REQ-031 cmd_start in RUN SHALL be ignored.
REQ-032 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE.
REQ-033 sweep_limit SHALL be sampled only at sweep completion.

Reset
REQ-034 While rst=1, the block SHALL force IDLE, cell_idx=0, sweeps_done=0, activity=0, converged=0, done=0, busy=0 and previous-grant=engine.
REQ-035 rst asserted mid-RUN SHALL abort immediately: eng_en=0 and mem_we=0 in that cycle, and the grid contents are left untouched.

Structure
REQ-036 A shared package SHALL hold the state enum (IDLE/RUN/DONE), N_CELLS_DEF=25, SWEEP_W_DEF=8, the mem_src encodings (SRC_ENG/SRC_HOST) and the address width 5.
REQ-037 One sub-module, sweep_arbiter, SHALL implement the two-requester alternating grant of REQ-023; the FSM, counters and status logic stay in stencil_sweep_ctrl.

Verification
REQ-038 Scenario: rst, then cmd_start with sweep_limit=3 and eng_delta_nz=1, no host traffic -> eng_en high 75 consecutive cycles, then done=1, sweeps_done=3, converged=0.
REQ-039 Scenario: sweep_limit=0, eng_delta_nz=1 for sweep 1 and 0 throughout sweep 2 -> DONE after cycle 50, converged=1, sweeps_done=2.
REQ-040 Scenario: RUN with host_req held high 10 cycles -> grants alternate host, eng, host, ... giving 5 host grants and 5 eng_en; cell_idx advances by exactly 5.
REQ-041 Scenario: cmd_stop at cell 12 of sweep 2 -> IDLE next cycle, sweeps_done=1, busy=0, done=0; a later cmd_start restarts at cell 0.
REQ-042 Scenario: same-cycle cmd_start+cmd_stop in IDLE -> stays IDLE; rst asserted mid-RUN -> mem_we=0 in that cycle and all outputs at reset values next cycle.
REQ-043 Scenario: in DONE, a host write to address 7 -> host_gnt=1, mem_we=1, mem_src=1, mem_addr=7 in the same cycle.

Source files
------------

// File: rtl/stencil_sweep_ctrl_pkg.sv
// Shared definitions for the stencil sweep controller.
//   - sweep_state_t : controller FSM states (IDLE / RUN / DONE)
//   - N_CELLS_DEF   : default number of grid cells per sweep
//   - SWEEP_W_DEF   : default width of the sweep limit / sweep counter
//   - ADDR_W        : grid address width
//   - SRC_ENG/HOST  : encodings of the grid write-data select (mem_src)
package stencil_sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_t;

    localparam int N_CELLS_DEF = 25;
    localparam int SWEEP_W_DEF = 8;
    localparam int ADDR_W      = 5;

    localparam logic SRC_ENG  = 1'b0;
    localparam logic SRC_HOST = 1'b1;

endpackage

// File: rtl/stencil_sweep_ctrl_arbiter.sv
// sweep_arbiter: single-port grid access arbiter between the host and the
// sweep engine. One access per cycle.
//   clk, rst  : clock and synchronous active-high reset
//   run       : controller is sweeping; engine wants the port every cycle
//   host_req  : host wants the port this cycle
//   host_gnt  : host owns the port this cycle
//   eng_gnt   : engine owns the port this cycle
// While running, a host that was granted last cycle yields the next cycle,
// so sustained contention alternates host/engine starting with the host.
// Outside RUN the host always owns the port. During reset nobody is granted
// so the grid cannot be written while the controller is being cleared.
module sweep_arbiter (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic host_req,
    output logic host_gnt,
    output logic eng_gnt
);

    // 1 = the previous RUN cycle went to the host; 0 = engine.
    logic prev_host_reg;

    always_comb begin
        host_gnt = 1'b0;
        eng_gnt  = 1'b0;
        if (!rst) begin
            if (run) begin
                host_gnt = host_req & ~prev_host_reg;
                eng_gnt  = ~host_gnt;
            end else begin
                host_gnt = host_req;
            end
        end
    end

    // History only tracks RUN cycles, so every run starts fresh with the
    // host having priority on the first contended cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_host_reg <= 1'b0;
        end else begin
            prev_host_reg <= run & host_gnt;
        end
    end

endmodule

// File: rtl/stencil_sweep_ctrl.sv
// stencil_sweep_ctrl: sequences repeated sweeps of an engine over grid cells
// 0..N_CELLS-1, sharing a single grid port with a host.
//   clk, rst        : clock and synchronous active-high reset
//   cmd_start/stop  : one-cycle run start / abort pulses (stop wins)
//   sweep_limit     : sweeps per run, 0 = run until converged
//   host_req/we/addr: host grid access request
//   host_gnt        : host access performed this cycle
//   eng_delta_nz    : engine's new value differs from the old one
//   eng_en          : engine update performed this cycle
//   mem_addr/we/src : grid port address, write strobe, write-data select
//   busy/done       : in RUN / in DONE
//   converged       : last run ended because a whole sweep changed nothing
//   sweeps_done     : completed sweeps of the current or last run
module stencil_sweep_ctrl
    import stencil_sweep_ctrl_pkg::*;
#(
    parameter int N_CELLS = N_CELLS_DEF,
    parameter int SWEEP_W = SWEEP_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_start,
    input  logic               cmd_stop,
    input  logic [SWEEP_W-1:0] sweep_limit,
    input  logic               host_req,
    input  logic               host_we,
    input  logic [ADDR_W-1:0]  host_addr,
    output logic               host_gnt,
    input  logic               eng_delta_nz,
    output logic               eng_en,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_we,
    output logic               mem_src,
    output logic               busy,
    output logic               done,
    output logic               converged,
    output logic [SWEEP_W-1:0] sweeps_done
);

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(N_CELLS - 1);

    sweep_state_t       state_reg;
    logic [ADDR_W-1:0]  cell_idx_reg;
    logic [SWEEP_W-1:0] sweeps_done_reg;
    logic               activity_reg;
    logic               converged_reg;

    logic               host_gnt_w;
    logic               eng_gnt_w;
    logic               last_cell;
    logic               activity_next;
    logic [SWEEP_W-1:0] sweeps_next;
    logic               limit_hit;

    sweep_arbiter u_arb (
        .clk      (clk),
        .rst      (rst),
        .run      (state_reg == RUN),
        .host_req (host_req),
        .host_gnt (host_gnt_w),
        .eng_gnt  (eng_gnt_w)
    );

    // Grid port mux: the engine writes its own cell, the host gets its
    // address and its write strobe only when it is granted.
    assign host_gnt = host_gnt_w;
    assign eng_en   = eng_gnt_w;
    assign mem_addr = eng_gnt_w ? cell_idx_reg : host_addr;
    assign mem_we   = eng_gnt_w | (host_gnt_w & host_we);
    assign mem_src  = eng_gnt_w ? SRC_ENG : SRC_HOST;

    assign busy        = (state_reg == RUN);
    assign done        = (state_reg == DONE);
    assign converged   = converged_reg;
    assign sweeps_done = sweeps_done_reg;

    // Sweep-completion arithmetic. The activity bit used for the
    // convergence decision must include the final cell's own flag.
    assign last_cell     = (cell_idx_reg == LAST_CELL);
    assign activity_next = activity_reg | eng_delta_nz;
    assign sweeps_next   = (sweeps_done_reg == '1) ? sweeps_done_reg
                                                   : sweeps_done_reg + SWEEP_W'(1);
    assign limit_hit     = (sweep_limit != '0) && (sweeps_next == sweep_limit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            cell_idx_reg    <= '0;
            sweeps_done_reg <= '0;
            activity_reg    <= 1'b0;
            converged_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (cmd_stop) begin
                        state_reg <= IDLE;
                    end else if (cmd_start) begin
                        state_reg       <= RUN;
                        cell_idx_reg    <= '0;
                        sweeps_done_reg <= '0;
                        activity_reg    <= 1'b0;
                        converged_reg   <= 1'b0;
                    end
                end
                RUN: begin
                    // The access of the stop cycle is still performed by the
                    // port mux; only the bookkeeping of that cycle is dropped,
                    // so a partial sweep never counts.
                    if (cmd_stop) begin
                        state_reg <= IDLE;
                    end else if (eng_gnt_w) begin
                        if (last_cell) begin
                            cell_idx_reg    <= '0;
                            sweeps_done_reg <= sweeps_next;
                            activity_reg    <= 1'b0;
                            if (!activity_next) begin
                                converged_reg <= 1'b1;
                                state_reg     <= DONE;
                            end else if (limit_hit) begin
                                state_reg <= DONE;
                            end
                        end else begin
                            cell_idx_reg <= cell_idx_reg + ADDR_W'(1);
                            activity_reg <= activity_next;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stencil_sweep_ctrl.sv
// Testbench for stencil_sweep_ctrl: a per-cycle vector table for the basic
// port behaviour, followed by multi-cycle sequences (limited run, convergence,
// host contention, stop mid-sweep, reset mid-run, counter saturation).
module tb_stencil_sweep_ctrl;
    import stencil_sweep_ctrl_pkg::*;

    localparam int NC = 25;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_start;
    logic          cmd_stop;
    logic [SW-1:0] sweep_limit;
    logic          host_req;
    logic          host_we;
    logic [4:0]    host_addr;
    logic          host_gnt;
    logic          eng_delta_nz;
    logic          eng_en;
    logic [4:0]    mem_addr;
    logic          mem_we;
    logic          mem_src;
    logic          busy;
    logic          done;
    logic          converged;
    logic [SW-1:0] sweeps_done;

    always #5 clk = ~clk;

    stencil_sweep_ctrl #(.N_CELLS(NC), .SWEEP_W(SW)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_start    (cmd_start),
        .cmd_stop     (cmd_stop),
        .sweep_limit  (sweep_limit),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_gnt     (host_gnt),
        .eng_delta_nz (eng_delta_nz),
        .eng_en       (eng_en),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_src      (mem_src),
        .busy         (busy),
        .done         (done),
        .converged    (converged),
        .sweeps_done  (sweeps_done)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Moves to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues a start pulse from IDLE/DONE; returns inside the first RUN cycle.
    task automatic pulse_start(input int limit);
        tick();
        cmd_start   = 1'b1;
        sweep_limit = SW'(limit);
        tick();
        cmd_start   = 1'b0;
    endtask

    // Runs engine-only cycles from the current cycle, checking each one is an
    // engine write of the expected cell. Stops early when DONE is seen.
    task automatic run_engine(input int max_cyc, input int quiet_after,
                              output int n, output int bad, output bit fin);
        n = 0;
        bad = 0;
        fin = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            eng_delta_nz = (n < quiet_after);
            #2;
            if (done === 1'b1) begin
                fin = 1'b1;
                break;
            end
            if (eng_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 5'(n % NC)) bad++;
            n++;
            tick();
        end
    endtask

    typedef struct {
        int start, stop, limit, req, we, addr, delta;
        int hg, ee, maddr, mwe, msrc, bsy, dn, conv, sd;
    } vec_t;

    vec_t vt [0:13];
    int   n_eng, n_bad, n_h, n_e, n_pat;
    bit   fin;
    logic exp_h;

    initial begin
        //        start stop lim req we addr dlt | hg ee ma we src bsy dn cv sd
        vt[0]  = '{0, 0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 1, 0, 0, 0, 0};
        vt[1]  = '{0, 0, 0, 1, 1,  3, 0,  1, 0,  3, 1, 1, 0, 0, 0, 0};
        vt[2]  = '{0, 0, 0, 1, 0,  9, 0,  1, 0,  9, 0, 1, 0, 0, 0, 0};
        vt[3]  = '{1, 1, 0, 0, 0,  0, 0,  0, 0,  0, 0, 1, 0, 0, 0, 0};
        vt[4]  = '{0, 0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 1, 0, 0, 0, 0};
        vt[5]  = '{1, 0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 1, 0, 0, 0, 0};
        vt[6]  = '{0, 0, 0, 0, 0,  0, 1,  0, 1,  0, 1, 0, 1, 0, 0, 0};
        vt[7]  = '{0, 0, 0, 1, 0, 20, 1,  1, 0, 20, 0, 1, 1, 0, 0, 0};
        vt[8]  = '{0, 0, 0, 1, 0, 20, 1,  0, 1,  1, 1, 0, 1, 0, 0, 0};
        vt[9]  = '{0, 0, 0, 1, 1,  4, 1,  1, 0,  4, 1, 1, 1, 0, 0, 0};
        vt[10] = '{0, 0, 0, 0, 0,  0, 1,  0, 1,  2, 1, 0, 1, 0, 0, 0};
        vt[11] = '{1, 0, 0, 0, 0,  0, 1,  0, 1,  3, 1, 0, 1, 0, 0, 0};
        vt[12] = '{0, 1, 0, 0, 0,  0, 1,  0, 1,  4, 1, 0, 1, 0, 0, 0};
        vt[13] = '{0, 0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 1, 0, 0, 0, 0};

        rst = 1'b1; cmd_start = 1'b0; cmd_stop = 1'b0; sweep_limit = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; eng_delta_nz = 1'b0;

        // Reset state, sampled while reset is held.
        repeat (3) tick();
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_conv", 32'(converged), 0);
        chk("rst_sd", 32'(sweeps_done), 0);
        chk("rst_eng_en", 32'(eng_en), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        $display("reset state checked");
        tick();
        rst = 1'b0;

        // Per-cycle vector table.
        for (int i = 0; i < 14; i++) begin
            if (i > 0) tick();
            cmd_start    = (vt[i].start != 0);
            cmd_stop     = (vt[i].stop != 0);
            sweep_limit  = SW'(vt[i].limit);
            host_req     = (vt[i].req != 0);
            host_we      = (vt[i].we != 0);
            host_addr    = 5'(vt[i].addr);
            eng_delta_nz = (vt[i].delta != 0);
            #2;
            chk($sformatf("v%0d_host_gnt", i), 32'(host_gnt), vt[i].hg);
            chk($sformatf("v%0d_eng_en", i), 32'(eng_en), vt[i].ee);
            chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), vt[i].maddr);
            chk($sformatf("v%0d_mem_we", i), 32'(mem_we), vt[i].mwe);
            chk($sformatf("v%0d_mem_src", i), 32'(mem_src), vt[i].msrc);
            chk($sformatf("v%0d_busy", i), 32'(busy), vt[i].bsy);
            chk($sformatf("v%0d_done", i), 32'(done), vt[i].dn);
            chk($sformatf("v%0d_conv", i), 32'(converged), vt[i].conv);
            chk($sformatf("v%0d_sd", i), 32'(sweeps_done), vt[i].sd);
            $display("vec %0d: gnt=%0b eng=%0b addr=%0d we=%0b busy=%0b", i,
                     host_gnt, eng_en, mem_addr, mem_we, busy);
        end
        tick();
        cmd_start = 1'b0; cmd_stop = 1'b0; host_req = 1'b0; host_we = 1'b0;
        eng_delta_nz = 1'b0;

        // Limited run: 3 sweeps of 25 engine cycles, always active.
        pulse_start(3);
        run_engine(200, 1 << 30, n_eng, n_bad, fin);
        chk("lim_fin", 32'(fin), 1);
        chk("lim_eng_cycles", n_eng, 75);
        chk("lim_addr_seq", n_bad, 0);
        chk("lim_sd", 32'(sweeps_done), 3);
        chk("lim_conv", 32'(converged), 0);
        chk("lim_busy", 32'(busy), 0);
        $display("limit run: %0d engine cycles, sweeps_done=%0d", n_eng, sweeps_done);

        // Host write while in DONE.
        tick();
        host_req = 1'b1; host_we = 1'b1; host_addr = 5'd7;
        #2;
        chk("done_wr_gnt", 32'(host_gnt), 1);
        chk("done_wr_we", 32'(mem_we), 1);
        chk("done_wr_src", 32'(mem_src), 1);
        chk("done_wr_addr", 32'(mem_addr), 7);
        chk("done_wr_eng", 32'(eng_en), 0);
        $display("done-state host write to addr %0d", mem_addr);
        tick();
        host_req = 1'b0; host_we = 1'b0;

        // Convergence: active first sweep, quiet second sweep.
        pulse_start(0);
        run_engine(200, NC, n_eng, n_bad, fin);
        chk("conv_fin", 32'(fin), 1);
        chk("conv_eng_cycles", n_eng, 50);
        chk("conv_addr_seq", n_bad, 0);
        chk("conv_flag", 32'(converged), 1);
        chk("conv_sd", 32'(sweeps_done), 2);
        $display("convergence run: %0d engine cycles, sweeps_done=%0d", n_eng, sweeps_done);

        // Host contention: 3 engine cycles, then host_req held 10 cycles.
        pulse_start(0);
        run_engine(3, 1 << 30, n_eng, n_bad, fin);
        chk("cont_pre_seq", n_bad, 0);
        n_h = 0; n_e = 0; n_pat = 0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 5'd17;
        for (int i = 0; i < 10; i++) begin
            #2;
            exp_h = ((i % 2) == 0);
            if (host_gnt !== exp_h) n_pat++;
            if (host_gnt === 1'b1 && eng_en === 1'b1) n_pat++;
            if (host_gnt === 1'b1) n_h++;
            if (eng_en === 1'b1) begin
                n_e++;
                if (mem_addr !== 5'(2 + n_e)) n_pat++;
            end
            tick();
        end
        host_req = 1'b0;
        #2;
        chk("cont_pattern", n_pat, 0);
        chk("cont_host_cnt", n_h, 5);
        chk("cont_eng_cnt", n_e, 5);
        chk("cont_next_addr", 32'(mem_addr), 8);
        chk("cont_next_eng", 32'(eng_en), 1);
        chk("cont_conv_clr", 32'(converged), 0);
        $display("contention: host=%0d eng=%0d next cell=%0d", n_h, n_e, mem_addr);
        tick();
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;

        // Stop at cell 12 of sweep 2, then restart.
        pulse_start(0);
        run_engine(NC + 12, 1 << 30, n_eng, n_bad, fin);
        chk("stop_pre_seq", n_bad, 0);
        cmd_stop = 1'b1;
        #2;
        chk("stop_cyc_eng", 32'(eng_en), 1);
        chk("stop_cyc_addr", 32'(mem_addr), 12);
        tick();
        cmd_stop = 1'b0;
        #2;
        chk("stop_busy", 32'(busy), 0);
        chk("stop_done", 32'(done), 0);
        chk("stop_sd", 32'(sweeps_done), 1);
        $display("stop mid-sweep: busy=%0b sweeps_done=%0d", busy, sweeps_done);

        // Restart begins at cell 0; then reset in the middle of sweep 2.
        pulse_start(0);
        run_engine(NC + 5, 1 << 30, n_eng, n_bad, fin);
        chk("restart_seq", n_bad, 0);
        #2;
        chk("prerst_sd", 32'(sweeps_done), 1);
        chk("prerst_busy", 32'(busy), 1);
        rst = 1'b1;
        #2;
        chk("rst_cyc_eng", 32'(eng_en), 0);
        chk("rst_cyc_we", 32'(mem_we), 0);
        tick();
        rst = 1'b0;
        #2;
        chk("postrst_busy", 32'(busy), 0);
        chk("postrst_done", 32'(done), 0);
        chk("postrst_conv", 32'(converged), 0);
        chk("postrst_sd", 32'(sweeps_done), 0);
        chk("postrst_eng", 32'(eng_en), 0);
        $display("reset mid-run: busy=%0b sweeps_done=%0d", busy, sweeps_done);

        // Saturation: 260 sweeps with no limit.
        pulse_start(0);
        run_engine(260 * NC, 1 << 30, n_eng, n_bad, fin);
        chk("sat_seq", n_bad, 0);
        #2;
        chk("sat_sd", 32'(sweeps_done), 255);
        chk("sat_busy", 32'(busy), 1);
        $display("saturation: sweeps_done=%0d after %0d engine cycles", sweeps_done, n_eng);
        tick();
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
